// File: rtl/draw_card_sprite_pkg.sv
// Shared types and constants for the card overlay stage.
// The ROM data generator uses the same CARD_W/CARD_H and transparent colour.
package card_pkg;

    // Card visibility / motion state.
    typedef enum logic [1:0] {
        HIDDEN  = 2'd0,
        SLIDING = 2'd1,
        SHOWN   = 2'd2
    } card_state_t;

    // ROM colour that lets the background show through.
    localparam logic [11:0] TRANSPARENT_RGB = 12'hF0F;

    // Sprite geometry (both powers of two).
    localparam int CARD_W = 32;
    localparam int CARD_H = 64;

endpackage

// File: rtl/draw_card_sprite_if.sv
// VGA pixel-stream bundle: beam position, sync/blank timing and colour.
// master drives the stream, slave consumes it.
interface draw_card_sprite_if;

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/draw_card_sprite_slide_fsm.sv
// Card motion controller: HIDDEN / SLIDING / SHOWN, frame tick and card X.
// card_x only moves on the frame tick (vsync rising edge) so a frame never
// shows the card at two positions.
module card_slide_fsm
    import card_pkg::*;
#(
    parameter int TARGET_X   = 100,
    parameter int DECK_X     = 700,
    parameter int SLIDE_STEP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync_i,
    input  logic        deal_i,
    input  logic        clear_i,
    output logic [10:0] card_x_o,
    output logic        visible_o,
    output logic        busy_o
);

    localparam logic [10:0] TARGET_C = 11'(TARGET_X);
    localparam logic [10:0] DECK_C   = 11'(DECK_X);
    localparam logic [10:0] STEP_C   = 11'(SLIDE_STEP);

    card_state_t state_q;
    logic [10:0] card_x_q;
    logic        vsync_q;
    logic        frame_tick_q;
    logic        visible_q;
    logic        busy_q;

    logic [10:0] dist_d;
    logic [10:0] step_x_d;

    // Distance to the slot and the position one step closer to it.
    always_comb begin
        dist_d   = 11'd0;
        step_x_d = card_x_q;
        if (card_x_q >= TARGET_C) begin
            dist_d   = card_x_q - TARGET_C;
            step_x_d = card_x_q - STEP_C;
        end else begin
            dist_d   = TARGET_C - card_x_q;
            step_x_d = card_x_q + STEP_C;
        end
    end

    // Frame tick detection, state transitions and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HIDDEN;
            card_x_q     <= DECK_C;
            vsync_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            visible_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            vsync_q      <= vsync_i;
            frame_tick_q <= vsync_i & ~vsync_q;
            case (state_q)
                HIDDEN: begin
                    // clear has priority when both pulses coincide
                    if (deal_i && !clear_i) begin
                        state_q   <= SLIDING;
                        card_x_q  <= DECK_C;
                        visible_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                SLIDING: begin
                    if (clear_i) begin
                        state_q   <= HIDDEN;
                        visible_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (frame_tick_q) begin
                        if (dist_d <= STEP_C) begin
                            card_x_q <= TARGET_C;
                            state_q  <= SHOWN;
                            busy_q   <= 1'b0;
                        end else begin
                            card_x_q <= step_x_d;
                        end
                    end
                end
                SHOWN: begin
                    if (clear_i) begin
                        state_q   <= HIDDEN;
                        visible_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= HIDDEN;
                    card_x_q  <= DECK_C;
                    visible_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign card_x_o  = card_x_q;
    assign visible_o = visible_q;
    assign busy_o    = busy_q;

endmodule

// File: rtl/draw_card_sprite.sv
// Per-card VGA overlay: addresses the suit ROM from the beam position, delays
// the pixel stream by two cycles to line up with ROM data, and merges the
// sprite over the background. The ROM samples rom_addr as its address register,
// so its data is ready for the second stage.
// Optional macro CARD_BORDER_EN: draws a black 1-pixel frame around the card.
module draw_card_sprite
    import card_pkg::*;
#(
    parameter int          MODULE_NUMBER = 0,
    parameter int          CARD_W        = card_pkg::CARD_W,
    parameter int          CARD_H        = card_pkg::CARD_H,
    parameter int          ADDR_WIDTH    = 11,
    parameter int          BASE_X        = 100,
    parameter int          SPACING       = 40,
    parameter int          CARD_Y        = 400,
    parameter int          DECK_X        = 700,
    parameter int          SLIDE_STEP    = 8,
    parameter logic [11:0] TRANSPARENT   = TRANSPARENT_RGB
) (
    input  logic                    clk,
    input  logic                    rst,
    draw_card_sprite_if.slave       vga_in,
    draw_card_sprite_if.master      vga_out,
    input  logic                    deal,
    input  logic                    clear,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    input  logic [11:0]             rom_pixel,
    output logic                    busy
);

    localparam int          H_BITS     = $clog2(CARD_W);
    localparam int          V_BITS     = $clog2(CARD_H);
    localparam logic [10:0] CARD_Y_C   = 11'(CARD_Y);
    localparam logic [11:0] CARD_Y_END = 12'(CARD_Y + CARD_H);

    logic [10:0] card_x_s;
    logic        visible_s;

    card_slide_fsm #(
        .TARGET_X   (BASE_X + MODULE_NUMBER * SPACING),
        .DECK_X     (DECK_X),
        .SLIDE_STEP (SLIDE_STEP)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .vsync_i   (vga_in.vsync),
        .deal_i    (deal),
        .clear_i   (clear),
        .card_x_o  (card_x_s),
        .visible_o (visible_s),
        .busy_o    (busy)
    );

    // Stage 1 combinational: sprite-relative offsets, hit test and ring flag.
    logic [H_BITS-1:0] hoff_d;
    logic [V_BITS-1:0] voff_d;
    logic              in_rect_d;
    logic              ring_d;

    // Hit test of the beam against the card rectangle.
    always_comb begin
        hoff_d    = H_BITS'(vga_in.hcount - card_x_s);
        voff_d    = V_BITS'(vga_in.vcount - CARD_Y_C);
        in_rect_d = 1'b0;
        if (visible_s
            && (vga_in.hcount >= card_x_s)
            && ({1'b0, vga_in.hcount} < ({1'b0, card_x_s} + 12'(CARD_W)))
            && (vga_in.vcount >= CARD_Y_C)
            && ({1'b0, vga_in.vcount} < CARD_Y_END)) begin
            in_rect_d = 1'b1;
        end else begin
            in_rect_d = 1'b0;
        end
`ifdef CARD_BORDER_EN
        if (in_rect_d && ((hoff_d == '0) || (hoff_d == '1)
                          || (voff_d == '0) || (voff_d == '1))) begin
            ring_d = 1'b1;
        end else begin
            ring_d = 1'b0;
        end
`else
        ring_d = 1'b0;
`endif
    end

    // Stage 1 registers.
    logic [10:0]           hcount_q1, vcount_q1;
    logic                  hsync_q1, vsync_q1, hblnk_q1, vblnk_q1;
    logic [11:0]           rgb_q1;
    logic                  in_rect_q1, ring_q1;
    logic [ADDR_WIDTH-1:0] rom_addr_q;

    // Stage 1: register timing, background, hit flags and the ROM address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_q1  <= 11'd0;
            vcount_q1  <= 11'd0;
            hsync_q1   <= 1'b0;
            vsync_q1   <= 1'b0;
            hblnk_q1   <= 1'b0;
            vblnk_q1   <= 1'b0;
            rgb_q1     <= 12'h000;
            in_rect_q1 <= 1'b0;
            ring_q1    <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            hcount_q1  <= vga_in.hcount;
            vcount_q1  <= vga_in.vcount;
            hsync_q1   <= vga_in.hsync;
            vsync_q1   <= vga_in.vsync;
            hblnk_q1   <= vga_in.hblnk;
            vblnk_q1   <= vga_in.vblnk;
            rgb_q1     <= vga_in.rgb;
            in_rect_q1 <= in_rect_d;
            ring_q1    <= ring_d;
            // a hidden card leaves the ROM address bus quiet
            if (visible_s) begin
                rom_addr_q <= {voff_d, hoff_d};
            end else begin
                rom_addr_q <= rom_addr_q;
            end
        end
    end

    // Stage 2 combinational: choose sprite, border, blank or background.
    logic [11:0] rgb_d;

    // Pixel merge priority: blanking, border ring, opaque sprite, background.
    always_comb begin
        rgb_d = rgb_q1;
        if (hblnk_q1 || vblnk_q1) begin
            rgb_d = 12'h000;
        end else if (ring_q1) begin
            rgb_d = 12'h000;
        end else if (in_rect_q1 && (rom_pixel != TRANSPARENT)) begin
            rgb_d = rom_pixel;
        end else begin
            rgb_d = rgb_q1;
        end
    end

    // Stage 2 registers.
    logic [10:0] hcount_q2, vcount_q2;
    logic        hsync_q2, vsync_q2, hblnk_q2, vblnk_q2;
    logic [11:0] rgb_q2;

    // Stage 2: second timing delay and merged pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_q2 <= 11'd0;
            vcount_q2 <= 11'd0;
            hsync_q2  <= 1'b0;
            vsync_q2  <= 1'b0;
            hblnk_q2  <= 1'b0;
            vblnk_q2  <= 1'b0;
            rgb_q2    <= 12'h000;
        end else begin
            hcount_q2 <= hcount_q1;
            vcount_q2 <= vcount_q1;
            hsync_q2  <= hsync_q1;
            vsync_q2  <= vsync_q1;
            hblnk_q2  <= hblnk_q1;
            vblnk_q2  <= vblnk_q1;
            rgb_q2    <= rgb_d;
        end
    end

    assign rom_addr       = rom_addr_q;
    assign vga_out.hcount = hcount_q2;
    assign vga_out.vcount = vcount_q2;
    assign vga_out.hsync  = hsync_q2;
    assign vga_out.vsync  = vsync_q2;
    assign vga_out.hblnk  = hblnk_q2;
    assign vga_out.vblnk  = vblnk_q2;
    assign vga_out.rgb    = rgb_q2;

endmodule

// File: doc/draw_card_sprite.md
Name: draw_card_sprite

Overview:
- Per-card VGA overlay stage that sits directly in front of the card-suit image ROM.
- Generates the ROM pixel address from the current VGA beam position and pipelines the VGA timing to match the ROM's 1-cycle read latency.
- Merges the returned ROM pixel over the incoming background.
- Runs a small FSM that slides the card from the deck to its table slot on a deal command. One instance per dealt card, indexed by MODULE_NUMBER.

Parameters:
- MODULE_NUMBER, 0, card slot index; selects target X and matches the paired ROM's index.
- CARD_W, 32, sprite width in pixels (power of two).
- CARD_H, 64, sprite height in pixels (power of two); CARD_W*CARD_H = 2**ADDR_WIDTH.
- ADDR_WIDTH, 11, ROM address width = log2(CARD_W)+log2(CARD_H).
- BASE_X, 100, X of slot 0; target X = BASE_X + MODULE_NUMBER*SPACING.
- SPACING, 40, horizontal pitch between slots.
- CARD_Y, 400, fixed top Y of card.
- DECK_X, 700, start X of slide.
- SLIDE_STEP, 8, pixels moved per frame.
- TRANSPARENT, 12'hF0F, ROM colour treated as see-through.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- hcount_in  in  11  beam X.
- vcount_in  in  11  beam Y.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  VGA timing.
- rgb_in  in  12  background pixel.
- deal  in  1  one-cycle pulse: start slide-in.
- clear  in  1  one-cycle pulse: hide card.
- rom_addr  out  ADDR_WIDTH  address to suit ROM (registered).
- rom_pixel  in  12  ROM dout, valid 1 cycle after rom_addr.
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/11/1/1/1/1  timing delayed 2 cycles.
- rgb_out  out  12  merged pixel.
- busy  out  1  high while sliding.

Behaviour:
- Reset: all outputs 0, FSM HIDDEN, card_x = DECK_X, frame_tick register 0.
- frame_tick: one-cycle pulse on the registered rising edge of vsync_in. card_x changes only on frame_tick, so there is no mid-frame tearing.
- FSM HIDDEN:
  - deal -> SLIDING, card_x <= DECK_X.
  - clear ignored.
- FSM SLIDING (busy = 1):
  - On frame_tick: if |card_x - target| <= SLIDE_STEP, card_x <= target and go to SHOWN; else card_x steps SLIDE_STEP toward target (either direction).
  - clear -> HIDDEN.
  - deal ignored.
- FSM SHOWN:
  - clear -> HIDDEN.
  - deal ignored.
- clear and deal in the same cycle: clear wins (result HIDDEN).
- Stage 1 (cycle +1):
  - in_rect = visible state (SLIDING or SHOWN) and card_x <= hcount_in < card_x+CARD_W and CARD_Y <= vcount_in < CARD_Y+CARD_H.
  - rom_addr <= {vcount_in-CARD_Y (log2 CARD_H bits), hcount_in-card_x (log2 CARD_W bits)}; computed in 11-bit unsigned, truncated.
  - Timing signals, rgb_in and in_rect are registered.
- Stage 2 (cycle +2):
  - Timing is registered again.
  - rgb_out <= rom_pixel if in_rect_d and rom_pixel != TRANSPARENT and neither blank_d is asserted; else rgb_in_d.
- Latency: fixed 2 cycles input to output, for all signals, in every FSM state.
- Blanking: rgb_out = 12'h000 whenever hblnk_d or vblnk_d is asserted.
- Reset asserted mid-slide: immediate return to HIDDEN and card_x = DECK_X; pipeline registers cleared.

Optional Feature:
- CARD_BORDER_EN defined:
  - Pixels on the outer 1-pixel ring of the card rectangle (row 0, row CARD_H-1, column 0, column CARD_W-1) output 12'h000 regardless of ROM data.
  - The ring flag is computed in stage 1 and delayed with in_rect.
- CARD_BORDER_EN undefined: no border; ring pixels come from the ROM like all others.

Decomposition:
- Package card_pkg holds:
  - typedef enum {HIDDEN, SLIDING, SHOWN} card_state_t.
  - Constant TRANSPARENT_RGB = 12'hF0F.
  - Constants CARD_W and CARD_H, shared with the ROM data generator.
- Natural sub-module: card_slide_fsm, containing the FSM, frame_tick and card_x register, and outputting card_x, visible and busy.

Test Plan:
- Reset, then a full frame with no deal -> rgb_out == rgb_in delayed exactly 2 cycles, rom_addr unchanged; timing outputs equal inputs delayed 2.
- MODULE_NUMBER=1, deal at reset defaults:
  - target 140; card_x goes 700 → 692 → … → 140.
  - SHOWN on the 70th frame_tick, busy low after it.
- In SHOWN at x=140, beam (150,410) -> rom_addr = {6'd10,5'd10} = 11'd330 one cycle later; rgb_out = ROM word 330 two cycles after the beam sample.
- ROM returns 12'hF0F inside the rect -> rgb_out = background; beam (139,410) or (172,410) -> background, no ROM pixel.
- clear and deal asserted in the same cycle while SLIDING -> HIDDEN, busy 0, card not drawn next frame; a later deal restarts from x=700.
- CARD_BORDER_EN defined, card SHOWN at 140, beam (140,420) and (171,463) -> rgb_out 12'h000; beam (141,401) -> ROM pixel.
